// File: rtl/ram_2r1w_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_2r1w_req_ctrl                                             |
// | Purpose  : valid/ready front end for a 2R1W RAM wrapper: zero-fill,      |
// |            credit-limited reads, per-lane response FIFOs, write bypass.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ram_2r1w_req_ctrl #(
    parameter int MEMD       = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int RD_LAT     = 1,
    parameter int RSP_DEPTH  = 4,
    parameter bit IZERO      = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [NUM_WMASKS-1:0]     wr_mask,
    input  logic [1:0]                rd_valid,
    output logic [1:0]                rd_ready,
    input  logic [2*ADDR_WIDTH-1:0]   rd_addr,
    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic                      init_done,
    output logic                      ram_csb,
    output logic                      ram_web,
    output logic [NUM_WMASKS-1:0]     ram_wmask,
    output logic [DATA_WIDTH-1:0]     ram_din,
    output logic [2*ADDR_WIDTH-1:0]   ram_addr,
    output logic                      ram_csb1,
    output logic [2*ADDR_WIDTH-1:0]   ram_addr1,
    input  logic [2*DATA_WIDTH-1:0]   ram_dout1
);

    localparam int c_lane_w = DATA_WIDTH / NUM_WMASKS;
    localparam int c_cnt_w  = $clog2(RSP_DEPTH + 1);
    localparam int c_ptr_w  = $clog2(RSP_DEPTH);
    localparam logic [c_cnt_w:0]      c_depth     = (c_cnt_w + 1)'(RSP_DEPTH);
    localparam logic [c_cnt_w-1:0]    c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]    c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0]    c_ptr_last  = c_ptr_w'(RSP_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(MEMD - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        c_st_init = 1'b0,
        c_st_run  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_init_addr;
    logic                    w_run;
    logic                    w_init_wr;
    logic                    w_wr_fire;
    logic [1:0]              w_rd_fire;
    logic [DATA_WIDTH-1:0]   w_wbits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IZERO ? c_st_init : c_st_run;
            r_init_addr <= '0;
        end else if (r_state == c_st_init) begin
            if (r_init_addr == c_last_addr) begin
                r_state <= c_st_run;
            end else begin
                r_init_addr <= r_init_addr + c_addr_one;
            end
        end
    end

    // rst overrides every handshake output in the same cycle it is high
    assign w_run     = !rst && (r_state == c_st_run);
    assign w_init_wr = !rst && (r_state == c_st_init);
    assign init_done = w_run;
    assign wr_ready  = w_run;
    assign w_wr_fire = wr_valid && wr_ready;

    for (genvar gm = 0; gm < NUM_WMASKS; gm++) begin : g_mask
        assign w_wbits[gm*c_lane_w +: c_lane_w] = {c_lane_w{wr_mask[gm]}};
    end

    always_comb begin
        ram_csb   = 1'b1;
        ram_web   = 1'b1;
        ram_wmask = '0;
        ram_din   = '0;
        ram_addr  = '0;
        if (w_init_wr) begin
            ram_csb   = 1'b0;
            ram_web   = 1'b0;
            ram_wmask = '1;
            ram_addr  = {2{r_init_addr}};
        end else if (w_wr_fire) begin
            ram_csb   = 1'b0;
            ram_web   = 1'b0;
            ram_wmask = wr_mask;
            ram_din   = wr_data;
            ram_addr  = {2{wr_addr}};
        end
    end

    assign ram_csb1 = ~|w_rd_fire;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_fire;
        logic                  w_collide;
        logic                  w_push;
        logic                  w_pop;
        logic [DATA_WIDTH-1:0] w_dout;
        logic [DATA_WIDTH-1:0] w_rsp;
        logic [c_cnt_w-1:0]    r_infl;
        logic [c_cnt_w-1:0]    r_cnt;
        logic [c_ptr_w-1:0]    r_wp;
        logic [c_ptr_w-1:0]    r_rp;
        logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
        logic                  r_pv  [RD_LAT];
        logic                  r_pc  [RD_LAT];
        logic [DATA_WIDTH-1:0] r_pd  [RD_LAT];
        logic [DATA_WIDTH-1:0] r_pm  [RD_LAT];

        assign w_addr          = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_ready[gi]    = w_run && (({1'b0, r_infl} + {1'b0, r_cnt}) < c_depth);
        assign w_fire          = rd_valid[gi] && rd_ready[gi];
        assign w_rd_fire[gi]   = w_fire;
        assign w_collide       = BYPASS && w_fire && w_wr_fire && (w_addr == wr_addr);
        assign ram_addr1[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_fire ? w_addr : '0;

        // Merge happens at the push so the pipe carries write data, not RAM data
        assign w_dout = ram_dout1[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_push = r_pv[RD_LAT-1];
        assign w_rsp  = r_pc[RD_LAT-1]
                      ? ((r_pd[RD_LAT-1] & r_pm[RD_LAT-1]) | (w_dout & ~r_pm[RD_LAT-1]))
                      : w_dout;

        assign rsp_valid[gi] = !rst && (r_cnt != '0);
        assign rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rp];
        assign w_pop = rsp_valid[gi] && rsp_ready[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_infl <= '0;
                r_cnt  <= '0;
                r_wp   <= '0;
                r_rp   <= '0;
                for (int k = 0; k < RD_LAT; k++) begin
                    r_pv[k] <= 1'b0;
                    r_pc[k] <= 1'b0;
                    r_pd[k] <= '0;
                    r_pm[k] <= '0;
                end
                for (int k = 0; k < RSP_DEPTH; k++) begin
                    r_mem[k] <= '0;
                end
            end else begin
                r_pv[0] <= w_fire;
                r_pc[0] <= w_collide;
                r_pd[0] <= wr_data;
                r_pm[0] <= w_wbits;
                for (int k = 1; k < RD_LAT; k++) begin
                    r_pv[k] <= r_pv[k-1];
                    r_pc[k] <= r_pc[k-1];
                    r_pd[k] <= r_pd[k-1];
                    r_pm[k] <= r_pm[k-1];
                end

                if (w_fire && !w_push) begin
                    r_infl <= r_infl + c_cnt_one;
                end else if (!w_fire && w_push) begin
                    r_infl <= r_infl - c_cnt_one;
                end

                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end else if (!w_push && w_pop) begin
                    r_cnt <= r_cnt - c_cnt_one;
                end

                if (w_push) begin
                    r_mem[r_wp] <= w_rsp;
                    r_wp        <= (r_wp == c_ptr_last) ? '0 : r_wp + c_ptr_one;
                end
                if (w_pop) begin
                    r_rp <= (r_rp == c_ptr_last) ? '0 : r_rp + c_ptr_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_2r1w_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_2r1w_req_ctrl                                          |
// | Purpose  : directed bench with a RAM stand-in and a timestamped model.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ram_2r1w_req_ctrl;

    localparam int MEMD      = 512;
    localparam int AW        = 9;
    localparam int DW        = 32;
    localparam int NWM       = 4;
    localparam int LW        = DW / NWM;
    localparam int RD_LAT    = 1;
    localparam int RSP_DEPTH = 4;
    localparam bit IZERO     = 1'b1;
    localparam bit BYPASS    = 1'b1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid, wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NWM-1:0]    wr_mask;
    logic [1:0]        rd_valid, rd_ready;
    logic [2*AW-1:0]   rd_addr;
    logic [1:0]        rsp_valid, rsp_ready;
    logic [2*DW-1:0]   rsp_data;
    logic              init_done;
    logic              ram_csb, ram_web, ram_csb1;
    logic [NWM-1:0]    ram_wmask;
    logic [DW-1:0]     ram_din;
    logic [2*AW-1:0]   ram_addr, ram_addr1;
    logic [2*DW-1:0]   ram_dout1;

    always #5 clk = ~clk;

    ram_2r1w_req_ctrl #(
        .MEMD(MEMD), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NWM),
        .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH), .IZERO(IZERO), .BYPASS(BYPASS)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask),
        .ram_din(ram_din), .ram_addr(ram_addr),
        .ram_csb1(ram_csb1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] expand(input logic [NWM-1:0] mk);
        logic [DW-1:0] r;
        r = '0;
        for (int b = 0; b < NWM; b++) if (mk[b]) r[b*LW +: LW] = '1;
        return r;
    endfunction

    // RAM stand-in: garbage while in reset so the zero-fill is observable
    logic [DW-1:0] ram [MEMD];
    logic [DW-1:0] rp0 [RD_LAT];
    logic [DW-1:0] rp1 [RD_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < MEMD; a++) ram[a] <= 32'hA5A5_0000 | a;
        end else if (!ram_csb && !ram_web) begin
            for (int b = 0; b < NWM; b++)
                if (ram_wmask[b]) ram[ram_addr[AW-1:0]][b*LW +: LW] <= ram_din[b*LW +: LW];
        end
        if (!ram_csb1) begin
            rp0[0] <= ram[ram_addr1[AW-1:0]];
            rp1[0] <= ram[ram_addr1[2*AW-1:AW]];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            rp0[k] <= rp0[k-1];
            rp1[k] <= rp1[k-1];
        end
    end
    assign ram_dout1 = {rp1[RD_LAT-1], rp0[RD_LAT-1]};

    // Model: memory image plus per-lane queue of (cycle available, data)
    logic [DW-1:0] mdl_mem [MEMD];
    logic [DW-1:0] exp_d [2][256];
    int            exp_t [2][256];
    int            head [2];
    int            tail [2];
    int            init_left = 0;
    int            cyc = 0;

    always @(negedge clk) begin
        logic [1:0]    exp_rdy, rfire;
        logic          wfire, ev;
        logic [DW-1:0] m, d;
        logic [AW-1:0] a;
        cyc++;
        if (rst) begin
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_rd_ready", rd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_ram_ctl", {ram_csb, ram_web, ram_csb1}, 3'b111);
            chk("rst_ram_addr", {ram_addr, ram_addr1}, 0);
            chk("rst_ram_din", {ram_din, ram_wmask}, 0);
            init_left = IZERO ? MEMD : 0;
            for (int i = 0; i < 2; i++) begin head[i] = 0; tail[i] = 0; end
        end else if (init_left > 0) begin
            a = AW'(MEMD - init_left);
            chk("init_done_low", init_done, 0);
            chk("init_wr_ready", wr_ready, 0);
            chk("init_rd_ready", rd_ready, 0);
            chk("init_ctl", {ram_csb, ram_web, ram_csb1}, 3'b001);
            chk("init_addr", ram_addr, {a, a});
            chk("init_din", {ram_din, ram_wmask}, {32'h0, 4'hF});
            mdl_mem[a] = '0;
            init_left--;
        end else begin
            chk("init_done", init_done, 1);
            chk("wr_ready", wr_ready, 1);
            for (int i = 0; i < 2; i++) begin
                exp_rdy[i] = (tail[i] - head[i]) < RSP_DEPTH;
                chk($sformatf("rd_ready%0d", i), rd_ready[i], exp_rdy[i]);
            end
            for (int i = 0; i < 2; i++) begin
                ev = (head[i] != tail[i]) && (exp_t[i][head[i] % 256] <= cyc);
                chk($sformatf("rsp_valid%0d", i), rsp_valid[i], ev);
                if (ev) begin
                    chk($sformatf("rsp_data%0d", i), rsp_data[i*DW +: DW], exp_d[i][head[i] % 256]);
                    if (rsp_ready[i]) head[i]++;
                end
            end
            wfire = wr_valid;
            rfire = rd_valid & exp_rdy;
            m     = expand(wr_mask);
            chk("ram_csb", ram_csb, !wfire);
            chk("ram_web", ram_web, !wfire);
            if (wfire) begin
                chk("ram_addr", ram_addr, {wr_addr, wr_addr});
                chk("ram_din", {ram_din, ram_wmask}, {wr_data, wr_mask});
            end
            chk("ram_csb1", ram_csb1, !(|rfire));
            chk("ram_addr1", ram_addr1,
                {rfire[1] ? rd_addr[2*AW-1:AW] : 9'h0, rfire[0] ? rd_addr[AW-1:0] : 9'h0});
            for (int i = 0; i < 2; i++) begin
                if (rfire[i]) begin
                    a = rd_addr[i*AW +: AW];
                    d = mdl_mem[a];
                    if (BYPASS && wfire && (a == wr_addr)) d = (wr_data & m) | (d & ~m);
                    exp_t[i][tail[i] % 256] = cyc + RD_LAT + 1;
                    exp_d[i][tail[i] % 256] = d;
                    tail[i]++;
                end
            end
            if (wfire) mdl_mem[wr_addr] = (wr_data & m) | (mdl_mem[wr_addr] & ~m);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NWM-1:0] wm, input logic [1:0] rv,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_valid = rv; rd_addr = {ra1, ra0};
        sync();
        wr_valid = 1'b0;
        rd_valid = 2'b00;
    endtask

    task automatic wait_init(output int cycles, output int writes);
        cycles = 0;
        writes = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!ram_csb && !ram_web) writes++;
        end while (!init_done && cycles < 2000);
    endtask

    task automatic wait_rsp(input int lane, output int lat, output logic [1:0] v,
                            output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[lane] && lat < 50);
        v  = rsp_valid;
        d0 = rsp_data[DW-1:0];
        d1 = rsp_data[2*DW-1:DW];
    endtask

    initial begin
        int            lat, cyc_n, wr_n, acc0, acc1;
        logic          f0;
        logic [1:0]    v;
        logic [DW-1:0] d0, d1;
        logic [AW-1:0] a0;

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_valid = 2'b00; rd_addr = '0; rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wait_init(cyc_n, wr_n);
        chk("init_cycles", cyc_n, MEMD + 1);
        chk("init_writes", wr_n, MEMD);
        sync();

        issue(0, 0, 0, 0, 2'b01, 9'h1FF, 9'h0);
        wait_rsp(0, lat, v, d0, d1);
        chk("zero_lat", lat, RD_LAT + 1);
        chk("zero_1ff", d0, 32'h0);
        sync();

        issue(1, 9'h040, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0);
        issue(0, 0, 0, 0, 2'b11, 9'h040, 9'h041);
        wait_rsp(0, lat, v, d0, d1);
        chk("wr_rd_lat", lat, RD_LAT + 1);
        chk("wr_rd_valid", v, 2'b11);
        chk("wr_rd_lane0", d0, 32'hDEADBEEF);
        chk("wr_rd_lane1", d1, 32'h0);
        sync();

        issue(1, 9'h040, 32'h11223344, 4'b0101, 2'b10, 0, 9'h040);
        wait_rsp(1, lat, v, d0, d1);
        chk("bypass_lat", lat, RD_LAT + 1);
        chk("bypass_data", d1, BYPASS ? 32'hDE22BE44 : 32'hDEADBEEF);
        sync();
        issue(0, 0, 0, 0, 2'b01, 9'h040, 0);
        wait_rsp(0, lat, v, d0, d1);
        chk("after_wr_data", d0, 32'hDE22BE44);
        sync();

        for (int j = 0; j < 8; j++)
            issue(1, AW'(9'h100 + j), 32'hA000_0100 + j, 4'hF, 2'b00, 0, 0);
        rsp_ready = 2'b10; rd_valid = 2'b11; a0 = 9'h100; rd_addr = {9'h101, a0};
        acc0 = 0; acc1 = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            f0 = rd_ready[0];
            if (f0) acc0++;
            if (rd_ready[1]) acc1++;
            sync();
            if (f0) begin a0 = a0 + 9'd1; rd_addr[AW-1:0] = a0; end
        end
        @(negedge clk);
        chk("bp_stall", rd_ready[0], 0);
        sync();
        chk("bp_accepts", acc0, RSP_DEPTH);
        chk("bp_lane1_accepts", acc1, 10);
        rd_valid = 2'b00; rsp_ready = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_rsp(0, lat, v, d0, d1);
            chk($sformatf("bp_order%0d", j), d0, 32'hA000_0100 + j);
        end
        sync();

        acc0 = 0; acc1 = 0; rd_valid = 2'b11;
        for (int j = 0; j < 100; j++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(j * 7);
            wr_data  = 32'h5A5A_0000 ^ (j * 32'h0101_0101);
            wr_mask  = NWM'(j) | NWM'(1);
            rd_addr  = {AW'(511 - j), AW'(j)};
            @(negedge clk);
            if (rd_ready[0]) acc0++;
            if (rd_ready[1]) acc1++;
            sync();
        end
        wr_valid = 1'b0; rd_valid = 2'b00;
        chk("stream_lane0", acc0, 100);
        chk("stream_lane1", acc1, 100);
        repeat (10) sync();

        rsp_ready = 2'b00;
        issue(0, 0, 0, 0, 2'b01, 9'h040, 0);
        issue(0, 0, 0, 0, 2'b01, 9'h100, 0);
        issue(0, 0, 0, 0, 2'b01, 9'h1FF, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        sync();
        rst = 1'b0; rsp_ready = 2'b11;
        repeat (199) @(posedge clk);
        @(negedge clk);
        chk("init_addr_199", ram_addr[AW-1:0], 9'd199);
        sync();
        rst = 1'b1;
        @(negedge clk);
        chk("midinit_csb", ram_csb, 1);
        sync();
        rst = 1'b0;
        wait_init(cyc_n, wr_n);
        chk("reinit_cycles", cyc_n, MEMD + 1);
        chk("reinit_writes", wr_n, MEMD);
        sync();
        issue(0, 0, 0, 0, 2'b11, 9'h040, 9'h100);
        wait_rsp(0, lat, v, d0, d1);
        chk("reinit_valid", v, 2'b11);
        chk("reinit_data", {d1, d0}, 64'h0);
        repeat (5) sync();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
